wrap_sequencer: RTL

Autonomous wrap (loopback) test engine for parallel channel "A". It sits on both sides of the wrap-test pin wrapper: it generates the 32-bit `test_driver` word that the wrapper registers onto the channel tags and bus, and it consumes the `test_receiver` word the wrapper returns. Running a fixed vector set, it checks the wrapped-back result against the wrap-cable mapping and reports pass/fail, an error count and the first failing vector, so cable and frontend checks no longer need host-driven register pokes.

---
 rtl/wrap_seq_pkg.sv | 34 +++
 rtl/wrap_seq_pattern.sv | 35 +++
 rtl/wrap_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wrap_seq_pkg.sv
// -----------------------------------------------------------------------------
// wrap_seq_pkg
// Shared definitions for the channel A wrap (loopback) test engine: FSM state
// encoding, the wrapped-line mask, the frontend-enable bit position, vector
// counts for both builds and the expected-loopback function.
// Optional feature macro used by the users of this package:
//   WRAP_SEQ_WALKING_ZERO_EN - adds the walking-zero vectors (indices 20..38).
// -----------------------------------------------------------------------------
package wrap_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } wrap_state_t;

  // Lines physically looped back by the wrap cable (bits 19:1).
  localparam logic [31:0] WRAP_MASK = 32'h000F_FFFE;

  localparam int FE_ENABLE_BIT = 31;

  // Walking-one covers indices 1..19; walking-zero adds 19 more.
  localparam int VEC_COUNT_BASE      = 20;
  localparam int VEC_COUNT_WALK_ZERO = 39;

  // The cable maps bits 19:1 straight through; everything else must read 0.
  function automatic logic [31:0] expected_wrap(input logic [31:0] driven);
    return driven & WRAP_MASK;
  endfunction

endpackage

// File: rtl/wrap_seq_pattern.sv
// -----------------------------------------------------------------------------
// wrap_seq_pattern
// Combinational index-to-pattern generator for the wrap test vector set.
//   index 0       : all zeros
//   index 1..19   : walking one, only bit <index> set
//   index 20..38  : walking zero over bits 19:1, bit (index-19) cleared
//                   (only when WRAP_SEQ_WALKING_ZERO_EN is defined)
// The frontend-enable bit is not part of the pattern; the caller adds it.
// Ports:
//   index   in  6  vector index
//   pattern out 32 data pattern (bit 0 and bits 31:20 always 0)
// Macro: WRAP_SEQ_WALKING_ZERO_EN enables the walking-zero generator.
// -----------------------------------------------------------------------------
module wrap_seq_pattern (
  input  logic [5:0]  index,
  output logic [31:0] pattern
);
  import wrap_seq_pkg::*;

  // Out-of-range indices yield all zeros so the generator is total.
  always_comb begin
    pattern = '0;
    if (index == '0) begin
      pattern = '0;
    end else if (index <= 6'd19) begin
      pattern = 32'd1 << index;
    end
`ifdef WRAP_SEQ_WALKING_ZERO_EN
    else if (index <= 6'd38) begin
      pattern = WRAP_MASK & ~(32'd1 << (index - 6'd19));
    end
`endif
  end

endmodule

// File: rtl/wrap_sequencer.sv
// -----------------------------------------------------------------------------
// wrap_sequencer
// Autonomous wrap test engine for parallel channel A. Drives a fixed vector set
// onto test_driver, waits SETTLE_CYCLES, compares test_receiver against the
// wrap-cable mapping and accumulates pass/fail, error count and the first
// failing vector.
// Parameter:
//   SETTLE_CYCLES  clocks between applying a vector and sampling (4..255)
// Ports:
//   clk                  in  1   clock
//   reset_n              in  1   async active-low reset
//   start                in  1   level-sensed run request (IDLE / DONE only)
//   test_driver          out 32  bit31 frontend enable, 19:1 wrapped lines
//   test_receiver        in  32  looped-back word from the wrapper
//   busy                 out 1   run in progress
//   done                 out 1   run finished, results valid
//   pass                 out 1   done with zero errors
//   error_count          out 8   failing vectors, saturating at 255
//   first_fail_index     out 6   index of first failing vector
//   first_fail_observed  out 32  test_receiver at first failure
// Macro: WRAP_SEQ_WALKING_ZERO_EN adds walking-zero vectors (39 instead of 20).
// -----------------------------------------------------------------------------
module wrap_sequencer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] test_driver,
  input  logic [31:0] test_receiver,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  error_count,
  output logic [5:0]  first_fail_index,
  output logic [31:0] first_fail_observed
);
  import wrap_seq_pkg::*;

`ifdef WRAP_SEQ_WALKING_ZERO_EN
  localparam logic [5:0] LAST_INDEX = 6'(VEC_COUNT_WALK_ZERO - 1);
`else
  localparam logic [5:0] LAST_INDEX = 6'(VEC_COUNT_BASE - 1);
`endif
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] FE_WORD     = 32'd1 << FE_ENABLE_BIT;

  wrap_state_t state, next_state;
  logic [7:0]  settle_cnt;
  logic [5:0]  index;
  logic [31:0] pattern;
  logic        accept_start;
  logic        mismatch;

  wrap_seq_pattern u_pattern (
    .index   (index),
    .pattern (pattern)
  );

  assign accept_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mismatch     = (state == ST_CHECK) && (test_receiver != expected_wrap(pattern));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic. ENABLE and SETTLE share one settle counter that restarts
  // on every state change, so both last exactly SETTLE_CYCLES clocks.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_ENABLE;
      ST_ENABLE: if (settle_cnt == SETTLE_LAST) next_state = ST_DRIVE;
      ST_DRIVE:  next_state = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) next_state = ST_CHECK;
      ST_CHECK:  next_state = (index == LAST_INDEX) ? ST_DONE : ST_DRIVE;
      ST_DONE:   if (start) next_state = ST_ENABLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Settle counter: zero on entry to any state, saturates to avoid wrap in
  // the long-lived IDLE/DONE states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 settle_cnt <= '0;
    else if (state != next_state) settle_cnt <= '0;
    else if (settle_cnt != 8'hFF) settle_cnt <= settle_cnt + 8'd1;
  end

  // Vector index advances as each CHECK hands over to the next DRIVE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     index <= '0;
    else if (accept_start)                            index <= '0;
    else if (state == ST_CHECK && index != LAST_INDEX) index <= index + 6'd1;
  end

  // Result accumulation. error_count never returns to zero within a run, so
  // it doubles as the "first failure already captured" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_count         <= '0;
      first_fail_index    <= '0;
      first_fail_observed <= '0;
    end else if (accept_start) begin
      error_count         <= '0;
      first_fail_index    <= '0;
      first_fail_observed <= '0;
    end else if (mismatch) begin
      if (error_count != 8'hFF) error_count <= error_count + 8'd1;
      if (error_count == 8'd0) begin
        first_fail_index    <= index;
        first_fail_observed <= test_receiver;
      end
    end
  end

  // Driver word is decoded from the state register, so an async reset drops
  // the frontend enable in the same cycle.
  always_comb begin
    test_driver = '0;
    case (state)
      ST_ENABLE:                    test_driver = FE_WORD;
      ST_DRIVE, ST_SETTLE, ST_CHECK: test_driver = FE_WORD | pattern;
      default:                      test_driver = '0;
    endcase
  end

  assign busy = (state == ST_ENABLE) || (state == ST_DRIVE) ||
                (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (error_count == 8'd0);

endmodule
